// File: rtl/mopshub_core.sv
// Simplified MOPS-Hub core: the downlink serialises e-link frames onto tx and waits for a CAN acknowledge,
// and the uplink deserialises frames from rx and hands them to the e-link writer.
module mopshub_core #(
    parameter int FRAME_W     = 76,
    parameter int BIT_DIV     = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    output logic               sign_on_sig,
    input  logic [FRAME_W-1:0] data_tra_uplink,
    input  logic               irq_elink,
    output logic               start_read_elink,
    output logic               end_read_elink,
    output logic               buffer_en,
    output logic [4:0]         can_tra_select,
    output logic               tx,
    output logic               send_mes_can_done,
    input  logic               irq_can_tra,
    output logic               end_can_proc,
    output logic               irq,
    output logic               irqstatus,
    input  logic               rx,
    input  logic [4:0]         can_rec_select,
    output logic [FRAME_W-1:0] data_rec_uplink,
    output logic               start_write_elink,
    output logic               send_mes_elink,
    input  logic               end_write_elink,
    input  logic               endwait
);
    localparam int SER_W = FRAME_W + 2;
    localparam int DIV_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam int IDX_W = $clog2(SER_W);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RXI_W = $clog2(FRAME_W);

    typedef enum logic [2:0] {SIGN_ON, IDLE, READ, LATCH, SEND, ACK_WAIT, DONE} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WRITE} rx_state_t;

    tx_state_t          r_tx_state, w_tx_next;
    logic               r_sign_on;
    logic [SER_W-1:0]   r_tx_shift;
    logic [DIV_W-1:0]   r_tx_div;
    logic [IDX_W-1:0]   r_tx_idx;
    logic [ACK_W-1:0]   r_ack_cnt;
    logic [4:0]         r_tra_sel;
    logic               r_irq;
    logic               r_irqstatus;
    logic               w_tx_bit_end;
    logic               w_ack_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= SIGN_ON;
        else     r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next     = r_tx_state;
        w_tx_bit_end  = (r_tx_div == DIV_W'(BIT_DIV - 1));
        w_ack_expired = (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
        case (r_tx_state)
            SIGN_ON:  if (r_sign_on) w_tx_next = IDLE;
            IDLE:     if (irq_elink) w_tx_next = READ;
            READ:     w_tx_next = LATCH;
            LATCH:    w_tx_next = SEND;
            SEND:     if (w_tx_bit_end && r_tx_idx == IDX_W'(SER_W - 1)) w_tx_next = ACK_WAIT;
            ACK_WAIT: if (irq_can_tra || w_ack_expired) w_tx_next = DONE;
            DONE:     w_tx_next = IDLE;
            default:  w_tx_next = SIGN_ON;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign_on   <= 1'b0;
            r_tx_shift  <= '1;
            r_tx_div    <= '0;
            r_tx_idx    <= '0;
            r_ack_cnt   <= '0;
            r_tra_sel   <= '0;
            r_irq       <= 1'b0;
            r_irqstatus <= 1'b0;
        end else begin
            r_sign_on <= (r_tx_state == SIGN_ON) && !r_sign_on;
            case (r_tx_state)
                READ: begin
                    // Start and stop bits are framed around the payload so SEND is a plain shift.
                    r_tx_shift  <= {1'b0, data_tra_uplink, 1'b1};
                    r_tra_sel   <= data_tra_uplink[FRAME_W-1 -: 5];
                    r_tx_div    <= '0;
                    r_tx_idx    <= '0;
                    r_irq       <= 1'b0;
                    r_irqstatus <= 1'b0;
                end
                SEND: begin
                    r_ack_cnt <= '0;
                    if (w_tx_bit_end) begin
                        r_tx_div   <= '0;
                        r_tx_idx   <= r_tx_idx + 1'b1;
                        r_tx_shift <= {r_tx_shift[SER_W-2:0], 1'b1};
                    end else begin
                        r_tx_div <= r_tx_div + 1'b1;
                    end
                end
                ACK_WAIT: begin
                    r_ack_cnt <= r_ack_cnt + 1'b1;
                    if (irq_can_tra) begin
                        r_irq       <= 1'b1;
                        r_irqstatus <= 1'b1;
                    end else if (w_ack_expired) begin
                        r_irq       <= 1'b1;
                        r_irqstatus <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sign_on_sig       = r_sign_on;
    assign buffer_en         = (r_tx_state == IDLE);
    assign start_read_elink  = (r_tx_state == READ);
    assign end_read_elink    = (r_tx_state == LATCH);
    assign can_tra_select    = r_tra_sel;
    assign tx                = (r_tx_state == SEND) ? r_tx_shift[SER_W-1] : 1'b1;
    assign send_mes_can_done = (r_tx_state == ACK_WAIT) && (r_ack_cnt == '0);
    assign end_can_proc      = (r_tx_state == DONE);
    assign irq               = r_irq;
    assign irqstatus         = r_irqstatus;

    rx_state_t            r_rx_state, w_rx_next;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    logic [DIV_W-1:0]     r_rx_div;
    logic [RXI_W-1:0]     r_rx_idx;
    logic [FRAME_W-6:0]   r_rx_shift;
    logic [FRAME_W-1:0]   r_rec;
    logic                 r_start_write;
    logic                 r_send_mes;
    logic                 w_rx_half;
    logic                 w_rx_full;
    logic                 w_rx_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= R_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_half = (r_rx_div == DIV_W'(BIT_DIV / 2 - 1));
        w_rx_full = (r_rx_div == DIV_W'(BIT_DIV - 1));
        w_rx_fall = r_rx_prev && !r_rx_s2;
        case (r_rx_state)
            R_IDLE:  if (w_rx_fall) w_rx_next = R_START;
            R_START: if (w_rx_half) w_rx_next = r_rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (w_rx_full && r_rx_idx == RXI_W'(FRAME_W - 1)) w_rx_next = R_STOP;
            R_STOP:  if (w_rx_full) w_rx_next = r_rx_s2 ? R_WRITE : R_IDLE;
            R_WRITE: if (end_write_elink || endwait) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    // The bus-id bits of the incoming frame shift out of the top; can_rec_select replaces them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1       <= 1'b1;
            r_rx_s2       <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_rx_div      <= '0;
            r_rx_idx      <= '0;
            r_rx_shift    <= '0;
            r_rec         <= '0;
            r_start_write <= 1'b0;
            r_send_mes    <= 1'b0;
        end else begin
            r_rx_s1       <= rx;
            r_rx_s2       <= r_rx_s1;
            r_rx_prev     <= r_rx_s2;
            r_start_write <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    r_rx_div <= '0;
                    r_rx_idx <= '0;
                end
                R_START: r_rx_div <= w_rx_half ? '0 : r_rx_div + 1'b1;
                R_DATA: begin
                    if (w_rx_full) begin
                        r_rx_div   <= '0;
                        r_rx_idx   <= r_rx_idx + 1'b1;
                        r_rx_shift <= {r_rx_shift[FRAME_W-7:0], r_rx_s2};
                    end else begin
                        r_rx_div <= r_rx_div + 1'b1;
                    end
                end
                R_STOP: begin
                    r_rx_div <= r_rx_div + 1'b1;
                    if (w_rx_full && r_rx_s2) begin
                        r_rec         <= {can_rec_select, r_rx_shift};
                        r_start_write <= 1'b1;
                        r_send_mes    <= 1'b1;
                    end
                end
                R_WRITE: if (end_write_elink || endwait) r_send_mes <= 1'b0;
                default: ;
            endcase
        end
    end

    assign data_rec_uplink   = r_rec;
    assign start_write_elink = r_start_write;
    assign send_mes_elink    = r_send_mes;

endmodule

// File: tb/tb_mopshub_core.sv
// Directed plus randomized bench for mopshub_core: downlink serialisation, acknowledge/timeout,
// uplink reception through a tx->rx loopback, bad stop bit and reset in mid-transmission.
module tb_mopshub_core;
    localparam int FRAME_W     = 76;
    localparam int BIT_DIV     = 4;
    localparam int ACK_TIMEOUT = 64;
    localparam int SER_W       = FRAME_W + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sign_on_sig;
    logic [FRAME_W-1:0] data_tra_uplink = '0;
    logic               irq_elink = 1'b0;
    logic               start_read_elink, end_read_elink, buffer_en;
    logic [4:0]         can_tra_select;
    logic               tx, send_mes_can_done;
    logic               irq_can_tra = 1'b0;
    logic               end_can_proc, irq, irqstatus;
    logic               rx;
    logic [4:0]         can_rec_select = '0;
    logic [FRAME_W-1:0] data_rec_uplink;
    logic               start_write_elink, send_mes_elink;
    logic               end_write_elink = 1'b0;
    logic               endwait = 1'b0;
    logic               loop_en = 1'b0;
    logic               rx_drv = 1'b1;

    int checks = 0;
    int errors = 0;
    int sw_cnt = 0;

    mopshub_core #(.FRAME_W(FRAME_W), .BIT_DIV(BIT_DIV), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .sign_on_sig(sign_on_sig),
        .data_tra_uplink(data_tra_uplink), .irq_elink(irq_elink),
        .start_read_elink(start_read_elink), .end_read_elink(end_read_elink),
        .buffer_en(buffer_en), .can_tra_select(can_tra_select), .tx(tx),
        .send_mes_can_done(send_mes_can_done), .irq_can_tra(irq_can_tra),
        .end_can_proc(end_can_proc), .irq(irq), .irqstatus(irqstatus),
        .rx(rx), .can_rec_select(can_rec_select), .data_rec_uplink(data_rec_uplink),
        .start_write_elink(start_write_elink), .send_mes_elink(send_mes_elink),
        .end_write_elink(end_write_elink), .endwait(endwait)
    );

    always #5 clk = ~clk;
    assign rx = loop_en ? tx : rx_drv;

    always @(posedge clk) if (start_write_elink) sw_cnt <= sw_cnt + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of serial slot k: start bit, frame MSB first, stop bit.
    function automatic logic ser_bit(input logic [FRAME_W-1:0] f, input int k);
        if (k == 0) return 1'b0;
        if (k == SER_W - 1) return 1'b1;
        return f[FRAME_W - k];
    endfunction

    function automatic logic [FRAME_W-1:0] rnd_frame();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[FRAME_W-1:0];
    endfunction

    task automatic release_reset(input string tag);
        rst = 1'b0;
        tick();
        chk({tag, "_sign_on_c1"}, sign_on_sig, 1'b1);
        chk({tag, "_buffer_en_c1"}, buffer_en, 1'b0);
        tick();
        chk({tag, "_sign_on_c2"}, sign_on_sig, 1'b0);
        chk({tag, "_buffer_en_c2"}, buffer_en, 1'b1);
        chk({tag, "_tx_idle"}, tx, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx"}, tx, 1'b1);
        chk({tag, "_outs"}, {sign_on_sig, start_read_elink, end_read_elink, buffer_en,
            send_mes_can_done, end_can_proc, irq, irqstatus, start_write_elink, send_mes_elink}, 10'b0);
        chk({tag, "_data_rec"}, data_rec_uplink, '0);
        chk({tag, "_can_tra_select"}, can_tra_select, 5'h0);
    endtask

    // One downlink transaction looped back into rx; ack_at<0 means no acknowledge at all.
    task automatic run_tx(input logic [FRAME_W-1:0] f, input int ack_at,
                          input logic [4:0] rsel, input bit use_endwait);
        int found, first, bad, dones, sw0, exp_first;
        logic got_irq, got_st;
        sw0 = sw_cnt;
        can_rec_select = rsel;
        loop_en = 1'b1;
        data_tra_uplink = f;
        irq_elink = 1'b1;
        found = -1;
        for (int c = 0; c < 8 && found < 0; c++) begin
            tick();
            if (start_read_elink) found = c;
        end
        chk("start_read_seen", found >= 0, 1'b1);
        chk("buffer_en_drop", buffer_en, 1'b0);
        irq_elink = 1'b0;
        tick();
        chk("end_read", end_read_elink, 1'b1);
        chk("start_read_one_cycle", start_read_elink, 1'b0);
        chk("can_tra_select", can_tra_select, f[FRAME_W-1 -: 5]);
        chk("irq_cleared_by_read", irq, 1'b0);
        bad = 0;
        dones = 0;
        for (int k = 0; k < SER_W * BIT_DIV; k++) begin
            tick();
            if (tx !== ser_bit(f, k / BIT_DIV)) bad++;
            if (send_mes_can_done) dones++;
        end
        chk("tx_wave_mismatches", bad, 0);
        chk("done_during_send", dones, 0);
        tick();
        chk("send_mes_can_done", send_mes_can_done, 1'b1);
        irq_can_tra = (ack_at == 0);
        first = -1;
        got_irq = 1'b0;
        got_st = 1'b0;
        for (int c = 1; c <= ACK_TIMEOUT + 2 && first < 0; c++) begin
            tick();
            if (end_can_proc) begin
                first = c;
                got_irq = irq;
                got_st = irqstatus;
            end else begin
                irq_can_tra = (c == ack_at);
            end
        end
        irq_can_tra = 1'b0;
        exp_first = (ack_at >= 0 && ack_at < ACK_TIMEOUT) ? ack_at + 1 : ACK_TIMEOUT;
        chk("end_can_proc_cycle", first, exp_first);
        chk("irq_at_done", got_irq, 1'b1);
        chk("irqstatus", got_st, (ack_at >= 0 && ack_at < ACK_TIMEOUT));
        tick();
        chk("end_can_proc_one_cycle", end_can_proc, 1'b0);
        chk("buffer_en_after_done", buffer_en, 1'b1);
        chk("irq_held", irq, 1'b1);
        found = -1;
        for (int c = 0; c < 24 && found < 0; c++) begin
            if (send_mes_elink) found = c;
            else tick();
        end
        tick();
        chk("rx_start_write_count", sw_cnt - sw0, 1);
        chk("rx_data", data_rec_uplink, {rsel, f[FRAME_W-6:0]});
        chk("send_mes_held", send_mes_elink, 1'b1);
        if (use_endwait) endwait = 1'b1;
        else end_write_elink = 1'b1;
        tick();
        endwait = 1'b0;
        end_write_elink = 1'b0;
        chk("send_mes_cleared", send_mes_elink, 1'b0);
    endtask

    // Bit-bangs a frame onto rx with a chosen stop bit.
    task automatic drive_rx(input logic [FRAME_W-1:0] f, input logic stop);
        loop_en = 1'b0;
        for (int k = 0; k < SER_W; k++) begin
            rx_drv = (k == SER_W - 1) ? stop : ser_bit(f, k);
            repeat (BIT_DIV) tick();
        end
        rx_drv = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        logic [FRAME_W-1:0] f, prev_rec;
        int sw0;

        #1;
        check_reset_outputs("reset");
        repeat (3) tick();
        check_reset_outputs("reset_held");
        release_reset("boot");

        run_tx({5'h1F, 7'h00, 64'h0123456789ABCDEF}, 2, 5'h03, 1'b1);
        run_tx(rnd_frame(), -1, 5'($urandom), 1'b0);
        run_tx(rnd_frame(), 0, 5'($urandom), 1'b1);
        run_tx(rnd_frame(), ACK_TIMEOUT - 1, 5'($urandom), 1'b0);
        run_tx(rnd_frame(), ACK_TIMEOUT, 5'($urandom), 1'b1);
        for (int i = 0; i < 3; i++)
            run_tx(rnd_frame(), int'($urandom_range(0, ACK_TIMEOUT + 8)), 5'($urandom), i[0]);

        prev_rec = data_rec_uplink;
        sw0 = sw_cnt;
        drive_rx(rnd_frame(), 1'b0);
        chk("bad_stop_no_write", sw_cnt - sw0, 0);
        chk("bad_stop_data_kept", data_rec_uplink, prev_rec);
        chk("bad_stop_send_mes", send_mes_elink, 1'b0);

        f = rnd_frame();
        can_rec_select = 5'h0A;
        drive_rx(f, 1'b1);
        chk("manual_rx_write", sw_cnt - sw0, 1);
        chk("manual_rx_data", data_rec_uplink, {5'h0A, f[FRAME_W-6:0]});
        endwait = 1'b1;
        tick();
        endwait = 1'b0;
        chk("manual_rx_release", send_mes_elink, 1'b0);

        loop_en = 1'b1;
        data_tra_uplink = '0;
        irq_elink = 1'b1;
        tick();
        irq_elink = 1'b0;
        tick();
        chk("midsend_latch", end_read_elink, 1'b1);
        repeat (100) tick();
        chk("midsend_tx_low", tx, ser_bit('0, 99 / BIT_DIV));
        rst = 1'b1;
        #1;
        check_reset_outputs("midsend_reset");
        repeat (2) tick();
        release_reset("reboot");
        repeat (SER_W * BIT_DIV) tick();
        chk("reboot_no_stray_write", send_mes_elink, 1'b0);
        chk("reboot_tx_idle", tx, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
